mips_register_hazard_unit: RTL
==============================

# mips_register_hazard_unit

Register hazard scoreboard for the pipelined MIPS core. It sits directly downstream of the decode-stage register control generator and consumes the resolved register control of the instruction in ID: read ports used, write address, write enable, and whether the write data comes from memory. It tracks in-flight destination registers through the EX, MEM and WB stages. From that state it raises a decode stall for unresolvable hazards and produces registered operand-forwarding selects for the instruction in EX.

## Interface
Parameters:
- `ADDR_W`, default 5: register address width.
- `COUNT_W`, default 16: width of the stall performance counter.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `decodeValid`  in  1: ID holds a real instruction.
- `decodeRead1Addr`  in  ADDR_W: port-1 address (Rs, or Rt for shifts).
- `decodeRead1Used`  in  1: port 1 operand consumed.
- `decodeRead2Addr`  in  ADDR_W: port-2 address (Rt).
- `decodeRead2Used`  in  1: port 2 operand consumed.
- `decodeWriteAddr`  in  ADDR_W: resolved destination (Rd or Rt).
- `decodeWriteEnable`  in  1: instruction writes the register file.
- `decodeWriteFromMemory`  in  1: write data source is memory (load).
- `pipeFreeze`  in  1: global freeze; no stage advances.
- `flush`  in  1: squash the ID instruction (taken branch/jump).
- `stall`  out  1: hold PC and IF/ID, inject bubble into EX; combinational.
- `forward1Sel`  out  2: EX operand 1 source; 0 regfile, 1 MEM result, 2 WB result.
- `forward2Sel`  out  2: same encoding for operand 2.
- `stallCount`  out  COUNT_W: saturating count of stall cycles.

## Operation
- Three scoreboard entries (EX, MEM, WB), each holding {valid write, addr, fromMemory}. An entry counts as a writer only if it is write-enabled, valid, and its addr != 0.
- Hazard match: a used read port whose addr equals a writer's addr; address 0 never matches.
- Stall, with forwarding compiled in: the EX entry is a load that matches either used port (load-use, one bubble).
- Stall, with forwarding compiled out: any match against the EX or MEM entry.
- The WB entry never causes a stall; the register file is write-before-read.
- `stall` is forced 0 when `decodeValid`=0 or `flush`=1.
- Advance, when `pipeFreeze`=0:
  - WB <= MEM, MEM <= EX.
  - EX <= decode info if `decodeValid` & !`stall` & !`flush`; otherwise EX <= bubble (writer invalid).
- Forward select, computed at decode for each port:
  - EX-entry match -> 1 (producer will be in MEM).
  - Else MEM-entry match -> 2 (producer will be in WB).
  - Else 0.
  - The youngest producer (EX) wins when both match.
  - Registered into `forwardNSel` on advance; a bubble loads 0.
- `pipeFreeze`=1: all entries, `forwardNSel` and `stallCount` hold. `stall` is still computed combinationally.
- `stallCount` increments on cycles with `stall`=1 & `pipeFreeze`=0, and saturates at all-ones.
- Reset: all entries invalid, `forward1Sel`=`forward2Sel`=0, `stallCount`=0. `stall` is therefore 0 after reset for any input.
- Reset mid-stream discards all in-flight entries. Reset has priority over `pipeFreeze` and `flush`.

## Timing
- `stall`: zero latency, a combinational function of decode inputs and registered state in the same cycle.
- `forwardNSel`: one cycle; valid during the cycle the instruction occupies EX.
- Load-use: exactly one stall cycle with forwarding; the consumer then sees select 2.
- Without forwarding: the consumer stalls until the producer reaches WB, i.e. up to 2 stall cycles.
- `flush` and `stall` in the same cycle: a bubble is inserted and `stall`=0.

## Configuration
- `MIPS_REGISTER_HAZARD_FORWARD_EN` defined:
  - Forwarding as above.
  - Stall only on load-use.
- Not defined:
  - `forward1Sel`/`forward2Sel` are tied to 0 with no forwarding logic.
  - Stall on any EX or MEM match.

## Test plan
- Back-to-back ALU dependency: `addu $3` then `addu` reading $3 on port 1 -> no stall; `forward1Sel`=1 in the consumer's EX cycle. With the macro off: 2 stall cycles, then select 0.
- Load-use: `lw $5` then an instruction reading $5 on port 2 -> `stall`=1 for one cycle, `stallCount`=1, consumer EX cycle `forward2Sel`=2.
- Register 0: `addu $0` then a reader of $0 on both ports -> `stall`=0, both selects 0.
- Double producer: writes to $7 in MEM and EX, reader of $7 -> select 1 (youngest).
- Freeze and flush: `pipeFreeze`=1 during a load-use -> `stall` held at 1, `stallCount` unchanged, entries unchanged. `flush`=1 in the same cycle as a hazard -> `stall`=0 and EX receives a bubble.
- Reset mid-stream: `reset`=1 with a load in EX -> next cycle all selects 0, `stallCount`=0, and a dependent reader does not stall.

Source files
------------

// File: rtl/mips_register_hazard_unit.sv
// Register hazard scoreboard: tracks EX/MEM/WB destinations, raises decode stall and
// registered forwarding selects. Define MIPS_REGISTER_HAZARD_FORWARD_EN to enable forwarding.
module mips_register_hazard_unit #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               decodeValid,
  input  logic [ADDR_W-1:0]  decodeRead1Addr,
  input  logic               decodeRead1Used,
  input  logic [ADDR_W-1:0]  decodeRead2Addr,
  input  logic               decodeRead2Used,
  input  logic [ADDR_W-1:0]  decodeWriteAddr,
  input  logic               decodeWriteEnable,
  input  logic               decodeWriteFromMemory,
  input  logic               pipeFreeze,
  input  logic               flush,
  output logic               stall,
  output logic [1:0]         forward1Sel,
  output logic [1:0]         forward2Sel,
  output logic [COUNT_W-1:0] stallCount
);

  // Writer flags already exclude address 0, so an address match implies a nonzero reader.
  logic              ex_wr_q, ex_wr_d, mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;
  logic [ADDR_W-1:0] ex_addr_q, ex_addr_d, mem_addr_q, mem_addr_d, wb_addr_q, wb_addr_d;
  logic              ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d, wb_ld_q, wb_ld_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic stall_raw, issue;

  always_comb begin
    hit1_ex  = decodeRead1Used && ex_wr_q  && (decodeRead1Addr == ex_addr_q);
    hit2_ex  = decodeRead2Used && ex_wr_q  && (decodeRead2Addr == ex_addr_q);
    hit1_mem = decodeRead1Used && mem_wr_q && (decodeRead1Addr == mem_addr_q);
    hit2_mem = decodeRead2Used && mem_wr_q && (decodeRead2Addr == mem_addr_q);
`ifdef MIPS_REGISTER_HAZARD_FORWARD_EN
    stall_raw = ex_ld_q && (hit1_ex || hit2_ex);
`else
    stall_raw = hit1_ex || hit2_ex || hit1_mem || hit2_mem;
`endif
    stall = decodeValid && !flush && stall_raw;
    issue = decodeValid && !stall && !flush;
  end

  always_comb begin
    ex_wr_d    = ex_wr_q;
    ex_addr_d  = ex_addr_q;
    ex_ld_d    = ex_ld_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_ld_d   = mem_ld_q;
    wb_wr_d    = wb_wr_q;
    wb_addr_d  = wb_addr_q;
    wb_ld_d    = wb_ld_q;
    count_d    = count_q;
    if (!pipeFreeze) begin
      wb_wr_d    = mem_wr_q;
      wb_addr_d  = mem_addr_q;
      wb_ld_d    = mem_ld_q;
      mem_wr_d   = ex_wr_q;
      mem_addr_d = ex_addr_q;
      mem_ld_d   = ex_ld_q;
      ex_wr_d    = issue && decodeWriteEnable && (decodeWriteAddr != '0);
      ex_addr_d  = decodeWriteAddr;
      ex_ld_d    = issue && decodeWriteFromMemory;
      if (stall && (count_q != {COUNT_W{1'b1}})) begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_wr_q    <= 1'b0;
      ex_addr_q  <= '0;
      ex_ld_q    <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_ld_q   <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_ld_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      ex_wr_q    <= ex_wr_d;
      ex_addr_q  <= ex_addr_d;
      ex_ld_q    <= ex_ld_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_ld_q   <= mem_ld_d;
      wb_wr_q    <= wb_wr_d;
      wb_addr_q  <= wb_addr_d;
      wb_ld_q    <= wb_ld_d;
      count_q    <= count_d;
    end
  end

  assign stallCount = count_q;

`ifdef MIPS_REGISTER_HAZARD_FORWARD_EN
  logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

  // Youngest producer (EX) takes priority over MEM.
  always_comb begin
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    if (!pipeFreeze) begin
      fwd1_d = 2'd0;
      fwd2_d = 2'd0;
      if (issue) begin
        fwd1_d = hit1_ex ? 2'd1 : (hit1_mem ? 2'd2 : 2'd0);
        fwd2_d = hit2_ex ? 2'd1 : (hit2_mem ? 2'd2 : 2'd0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fwd1_q <= 2'd0;
      fwd2_q <= 2'd0;
    end else begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  assign forward1Sel = fwd1_q;
  assign forward2Sel = fwd2_q;
`else
  assign forward1Sel = 2'd0;
  assign forward2Sel = 2'd0;
`endif

  // WB entry and MEM load flag are tracked for completeness but never steer a decision.
  logic unused_state;
  assign unused_state = ^{wb_wr_q, wb_addr_q, wb_ld_q, mem_ld_q, ex_ld_q};

endmodule
